// File: rtl/soc_pio_pkg.sv
// Constants shared by the PIO input and output blocks: register word addresses
// and the edge-capture encodings.
package soc_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RSVD = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/alarm_status_in_pio_if.sv
// Avalon-MM slave bus plus interrupt line of the alarm/status input PIO.
interface alarm_status_in_pio_if;

    // Write when chipselect && !write_n; read when chipselect && write_n, with
    // readdata valid on the cycle after the read is sampled and held until the next read.
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/pio_sync_edge.sv
// Input synchroniser with a one-cycle delayed copy and per-bit edge detection,
// held off after reset until the synchroniser holds real samples.
module pio_sync_edge
    import soc_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_port_i,
    output logic [DATA_WIDTH-1:0] sync_o,
    output logic [DATA_WIDTH-1:0] ev_o
);

    localparam int              ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
    logic [DATA_WIDTH-1:0]                  prev_q;
    logic [ARM_W-1:0]                       arm_q, arm_d;
    logic                                   armed;
    logic [DATA_WIDTH-1:0]                  rise, fall;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_port_i};
        armed  = (arm_q == ARM_DONE);
        arm_d  = armed ? arm_q : arm_q + 1'b1;
        sync_o = sync_q[SYNC_STAGES-1];
        rise   = sync_o & ~prev_q;
        fall   = ~sync_o & prev_q;
        ev_o   = '0;
        // Until armed, prev still holds reset zeros, so lines high at reset would look like edges.
        if (armed) begin
            if (EDGE_TYPE == EDGE_FALLING) begin
                ev_o = fall;
            end else if (EDGE_TYPE == EDGE_ANY) begin
                ev_o = rise | fall;
            end else begin
                ev_o = rise;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
            arm_q  <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_o;
            arm_q  <= arm_d;
        end
    end

endmodule

// File: rtl/alarm_status_in_pio.sv
// Alarm/status input PIO: synchronised level, sticky edge capture with
// write-one-to-clear, interrupt mask and a registered Avalon-MM read port.
module alarm_status_in_pio
    import soc_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_port,
    alarm_status_in_pio_if.slave  avs
);

    logic [DATA_WIDTH-1:0] sync;
    logic [DATA_WIDTH-1:0] ev;
    logic [DATA_WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [DATA_WIDTH-1:0] clr;
    logic [31:0]           readdata_q, readdata_d;
    logic [31:0]           rd_word;
    logic                  irq_q, irq_d;
    logic                  wr_en, rd_en;

    pio_sync_edge #(
        .DATA_WIDTH (DATA_WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_TYPE  (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port_i(in_port),
        .sync_o   (sync),
        .ev_o     (ev)
    );

    always_comb begin
        wr_en = avs.chipselect && !avs.write_n;
        rd_en = avs.chipselect && avs.write_n;

        clr = '0;
        if (wr_en && (avs.address == ADDR_EDGE)) begin
            clr = avs.writedata[DATA_WIDTH-1:0];
        end
        // A new event on a bit being cleared in the same cycle keeps the bit set.
        edge_capture_d = (edge_capture_q & ~clr) | ev;

        irq_mask_d = irq_mask_q;
        if (wr_en && (avs.address == ADDR_MASK)) begin
            irq_mask_d = avs.writedata[DATA_WIDTH-1:0];
        end

        irq_d = |(edge_capture_q & irq_mask_q);

        rd_word = '0;
        case (avs.address)
            ADDR_DATA: rd_word[DATA_WIDTH-1:0] = sync;
            ADDR_MASK: rd_word[DATA_WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE: rd_word[DATA_WIDTH-1:0] = edge_capture_q;
            default:   rd_word = '0;
        endcase
        readdata_d = rd_en ? rd_word : readdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture_q <= '0;
            irq_mask_q     <= '0;
            readdata_q     <= '0;
            irq_q          <= 1'b0;
        end else begin
            edge_capture_q <= edge_capture_d;
            irq_mask_q     <= irq_mask_d;
            readdata_q     <= readdata_d;
            irq_q          <= irq_d;
        end
    end

    assign avs.readdata = readdata_q;
    assign avs.irq      = irq_q;

endmodule

// File: tb/tb_alarm_status_in_pio.sv
// Three PIO instances (rising/32b, falling/32b, any/16b) share one stimulus stream;
// each has its own cycle-level reference model and read scoreboard.
module tb_alarm_status_in_pio;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] in_port = 32'hFFFF_FFFF;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int          DW  = (g == 2) ? 16 : 32;
    localparam logic [31:0] DWM = (DW == 32) ? 32'hFFFF_FFFF : ((32'd1 << DW) - 32'd1);

    alarm_status_in_pio_if u_bus ();
    assign u_bus.address    = address;
    assign u_bus.chipselect = chipselect;
    assign u_bus.write_n    = write_n;
    assign u_bus.writedata  = writedata;

    alarm_status_in_pio #(
      .DATA_WIDTH (DW),
      .SYNC_STAGES(SYNC),
      .EDGE_TYPE  (g)
    ) u_dut (
      .clk    (clk),
      .reset_n(reset_n),
      .in_port(in_port[DW-1:0]),
      .avs    (u_bus.slave)
    );

    // Reference model: hist holds in_port as seen at the last few clock edges.
    // The level software sees lags the pin by SYNC edges; edges are counted
    // only once SYNC+1 edges have passed since reset.
    logic [31:0] hist[$];
    logic [31:0] exp_q[$];
    int          edges = 0;
    logic [31:0] m_cap = '0, m_mask = '0, m_rdata = '0;
    logic        m_irq = 1'b0, chk = 1'b0;

    always @(posedge clk or negedge reset_n) begin : mdl
      logic [31:0] level, older, rise, fall, ev, clr, rd_val;
      if (!reset_n) begin
        hist.delete();
        for (int i = 0; i < SYNC + 1; i++) hist.push_back('0);
        exp_q.delete();
        edges = 0; m_cap = '0; m_mask = '0; m_rdata = '0; m_irq = 1'b0; chk = 1'b0;
      end else begin
        level = hist[hist.size() - SYNC];
        older = hist[hist.size() - SYNC - 1];
        rise  = level & ~older;
        fall  = ~level & older;
        ev    = '0;
        if (edges >= SYNC + 1) ev = (g == 0) ? rise : (g == 1) ? fall : (rise | fall);
        clr = (chipselect && !write_n && address == 2'd3) ? writedata : '0;
        if (chipselect && write_n) begin
          case (address)
            2'd0:    rd_val = level;
            2'd2:    rd_val = m_mask;
            2'd3:    rd_val = m_cap;
            default: rd_val = '0;
          endcase
          exp_q.push_back(rd_val);
          m_rdata = rd_val;
          chk = 1'b1;
        end else begin
          chk = 1'b0;
        end
        m_irq = |(m_cap & m_mask);
        m_cap = ((m_cap & ~clr) | ev) & DWM;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata & DWM;
        hist.push_back(in_port & DWM);
        if (hist.size() > SYNC + 2) void'(hist.pop_front());
        edges++;
      end
    end

    always @(negedge clk) begin : mon
      logic [31:0] e;
      if (chk) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rd_empty[g%0d] got %h required an expected entry", g, u_bus.readdata);
        end else begin
          e = exp_q.pop_front();
          if (u_bus.readdata !== e) begin
            n_bad++;
            $display("FAIL rdata[g%0d] t=%0t got %h required %h", g, $time, u_bus.readdata, e);
          end
        end
      end else begin
        n_cmp++;
        if (u_bus.readdata !== m_rdata) begin
          n_bad++;
          $display("FAIL rdata_hold[g%0d] t=%0t got %h required %h", g, $time, u_bus.readdata, m_rdata);
        end
      end
      n_cmp++;
      if (u_bus.irq !== m_irq) begin
        n_bad++;
        $display("FAIL irq[g%0d] t=%0t got %b required %b", g, $time, u_bus.irq, m_irq);
      end
    end
  end

  task automatic idle(input int n);
    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(1);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // Reset with all inputs high: no spurious edge, DATA reads all ones.
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    idle(10);
    rd(2'd0); rd(2'd3); idle(3);

    // Rising edge on bits 0 and 2, then unmask bit 2.
    in_port = '0;
    idle(5);
    wr(2'd3, 32'hFFFF_FFFF); idle(3);
    in_port = 32'h0000_0005;
    rd(2'd3); rd(2'd3); rd(2'd3); rd(2'd3);
    wr(2'd2, 32'h0000_0004); idle(2);
    rd(2'd3); idle(2);

    // Clear bit 2 only.
    wr(2'd3, 32'h0000_0004); rd(2'd3); idle(3);

    // Clear coinciding with a new rising edge on bit 2.
    in_port = 32'h0000_0001; idle(5);
    in_port = 32'h0000_0005; idle(6);
    in_port = 32'h0000_0001; idle(5);
    in_port = 32'h0000_0005; idle(2);
    wr(2'd3, 32'h0000_0004); idle(3);
    rd(2'd3); idle(2);

    // Bit 7 toggles with clears in between.
    wr(2'd3, 32'hFFFF_FFFF); in_port = '0; idle(6);
    wr(2'd3, 32'hFFFF_FFFF); idle(2);
    for (int k = 0; k < 4; k++) begin
      in_port[7] = ~in_port[7];
      idle(5);
      rd(2'd3);
      wr(2'd3, 32'h0000_0080);
      rd(2'd3);
      idle(1);
    end

    // Back-to-back reads and an ignored write to DATA.
    in_port = 32'hA5C3_0F96; idle(4);
    rd(2'd0); rd(2'd2); rd(2'd3); rd(2'd1);
    wr(2'd0, 32'h0000_1234); rd(2'd0);
    wr(2'd1, 32'hFFFF_FFFF); rd(2'd1);
    idle(2);

    // Randomised traffic with a reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      if ($urandom_range(0, 3) == 0) in_port ^= (32'd1 << $urandom_range(0, 31));
      if ($urandom_range(0, 40) == 0) in_port = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: idle(1);
        4, 5, 6:    rd(2'($urandom_range(0, 3)));
        default:    wr(2'($urandom_range(0, 3)),
                       ($urandom_range(0, 1) == 1) ? $urandom : (32'd1 << $urandom_range(0, 31)));
      endcase
    end
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
